// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port owner: arbitrates MMIO, DCache and ICache requests
// (fixed priority IO > DC > IC) and serializes each grant into byte cycles.
module mem_port_arbiter #(
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    clearIn,
  input  logic [7:0]              memIn,
  output logic [31:0]             memAddr,
  output logic [7:0]              memOut,
  output logic                    readWriteOut,
  input  logic                    icReqIn,
  input  logic [31-BLOCK_WIDTH:0] icAddrIn,
  output logic                    icDoneOut,
  output logic [BLOCK_SIZE*8-1:0] icLineOut,
  input  logic                    dcReqIn,
  input  logic                    dcWriteIn,
  input  logic [31-BLOCK_WIDTH:0] dcAddrIn,
  input  logic [BLOCK_SIZE*8-1:0] dcLineIn,
  output logic                    dcDoneOut,
  output logic [BLOCK_SIZE*8-1:0] dcLineOut,
  input  logic                    ioReqIn,
  input  logic                    ioWriteIn,
  input  logic [1:0]              ioSizeIn,
  input  logic [31:0]             ioAddrIn,
  input  logic [31:0]             ioDataIn,
  output logic                    ioDoneOut,
  output logic [31:0]             ioDataOut,
  output logic                    busyOut
);

  localparam int CNT_W = BLOCK_WIDTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OWN_IO = 2'd0;
  localparam logic [1:0] OWN_DC = 2'd1;
  localparam logic [1:0] OWN_IC = 2'd2;

  typedef logic [BLOCK_SIZE-1:0][7:0] line_t;

  logic [1:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic             write_q, write_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  line_t            wdata_q, wdata_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_out_q, mem_out_d;
  logic             rw_q, rw_d;
  line_t            ic_line_q, ic_line_d;
  line_t            dc_line_q, dc_line_d;
  logic [3:0][7:0]  io_data_q, io_data_d;

  logic [CNT_W-1:0]       io_len;
  logic [BLOCK_WIDTH-1:0] next_idx;
  logic [BLOCK_WIDTH-1:0] lane;
  logic                   last_wr_byte;
  logic                   last_rd_addr;
  logic                   last_rd_capture;

  always_comb begin
    case (ioSizeIn)
      2'b01:   io_len = CNT_W'(1);
      2'b10:   io_len = CNT_W'(2);
      default: io_len = CNT_W'(4);
    endcase
  end

  // A read byte lands one cycle after its address, so lane trails the counter by one.
  assign next_idx        = cnt_q[BLOCK_WIDTH-1:0] + BLOCK_WIDTH'(1);
  assign lane            = cnt_q[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);
  assign last_wr_byte    = (cnt_q == len_q - CNT_W'(1));
  assign last_rd_addr    = (cnt_q == len_q - CNT_W'(1));
  assign last_rd_capture = (cnt_q == len_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    write_d    = write_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    mem_out_d  = mem_out_q;
    rw_d       = rw_q;
    ic_line_d  = ic_line_q;
    dc_line_d  = dc_line_q;
    io_data_d  = io_data_q;

    case (state_q)
      ST_IDLE: begin
        if (ioReqIn && (ioSizeIn != 2'b00)) begin
          owner_d       = OWN_IO;
          write_d       = ioWriteIn;
          len_d         = io_len;
          wdata_d       = '0;
          wdata_d[3:0]  = ioDataIn;
          mem_addr_d    = ioAddrIn;
          state_d       = ST_XFER;
        end else if (dcReqIn) begin
          owner_d       = OWN_DC;
          write_d       = dcWriteIn;
          len_d         = CNT_W'(BLOCK_SIZE);
          wdata_d       = dcLineIn;
          mem_addr_d    = {dcAddrIn, {BLOCK_WIDTH{1'b0}}};
          state_d       = ST_XFER;
        end else if (icReqIn && !clearIn) begin
          owner_d       = OWN_IC;
          write_d       = 1'b0;
          len_d         = CNT_W'(BLOCK_SIZE);
          wdata_d       = '0;
          mem_addr_d    = {icAddrIn, {BLOCK_WIDTH{1'b0}}};
          state_d       = ST_XFER;
        end

        if (state_d == ST_XFER) begin
          cnt_d     = '0;
          mem_out_d = wdata_d[0];
          rw_d      = ~write_d;
          // Reads deposit only N lanes, so the MMIO result must start from zero.
          if (owner_d == OWN_IO && !write_d) begin
            io_data_d = '0;
          end
        end
      end

      ST_XFER: begin
        if (owner_q == OWN_IC && clearIn) begin
          state_d = ST_IDLE;
          rw_d    = 1'b1;
        end else if (write_q) begin
          if (last_wr_byte) begin
            state_d = ST_DONE;
            rw_d    = 1'b1;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            mem_addr_d = mem_addr_q + 32'd1;
            mem_out_d  = wdata_q[next_idx];
          end
        end else begin
          if (cnt_q != '0) begin
            case (owner_q)
              OWN_IO:  io_data_d[lane[1:0]] = memIn;
              OWN_DC:  dc_line_d[lane]      = memIn;
              default: ic_line_d[lane]      = memIn;
            endcase
          end
          if (last_rd_capture) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!last_rd_addr) begin
              mem_addr_d = mem_addr_q + 32'd1;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        rw_d    = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        rw_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IO;
      write_q    <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      mem_addr_q <= '0;
      mem_out_q  <= '0;
      rw_q       <= 1'b1;
      ic_line_q  <= '0;
      dc_line_q  <= '0;
      io_data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q    <= state_d;
      owner_q    <= owner_d;
      write_q    <= write_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      mem_out_q  <= mem_out_d;
      rw_q       <= rw_d;
      ic_line_q  <= ic_line_d;
      dc_line_q  <= dc_line_d;
      io_data_q  <= io_data_d;
    end
  end

  assign memAddr      = mem_addr_q;
  assign memOut       = mem_out_q;
  assign readWriteOut = rw_q;
  assign busyOut      = (state_q != ST_IDLE);

  // A flush landing in the IC done cycle still suppresses the pulse.
  assign icDoneOut = (state_q == ST_DONE) && (owner_q == OWN_IC) && !clearIn;
  assign dcDoneOut = (state_q == ST_DONE) && (owner_q == OWN_DC);
  assign ioDoneOut = (state_q == ST_DONE) && (owner_q == OWN_IO);

  assign icLineOut = ic_line_q;
  assign dcLineOut = dc_line_q;
  assign ioDataOut = io_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-RAM bus model plus a flat-array golden memory
// that predicts every read result and every committed write.
module tb_mem_port_arbiter;

  localparam int BW    = 4;
  localparam int BS    = 16;
  localparam int RAM_W = 18;
  localparam int K_IO  = 1;
  localparam int K_DC  = 2;
  localparam int K_IC  = 3;

  logic         clkIn = 1'b0;
  logic         resetIn;
  logic         clearIn;
  logic [7:0]   memIn;
  logic [31:0]  memAddr;
  logic [7:0]   memOut;
  logic         readWriteOut;
  logic         icReqIn;
  logic [27:0]  icAddrIn;
  logic         icDoneOut;
  logic [127:0] icLineOut;
  logic         dcReqIn;
  logic         dcWriteIn;
  logic [27:0]  dcAddrIn;
  logic [127:0] dcLineIn;
  logic         dcDoneOut;
  logic [127:0] dcLineOut;
  logic         ioReqIn;
  logic         ioWriteIn;
  logic [1:0]   ioSizeIn;
  logic [31:0]  ioAddrIn;
  logic [31:0]  ioDataIn;
  logic         ioDoneOut;
  logic [31:0]  ioDataOut;
  logic         busyOut;

  logic [7:0]  ram  [0:(1<<RAM_W)-1];
  logic [7:0]  gold [0:(1<<RAM_W)-1];
  logic [31:0] prev_addr = '0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn),
    .memIn(memIn), .memAddr(memAddr), .memOut(memOut), .readWriteOut(readWriteOut),
    .icReqIn(icReqIn), .icAddrIn(icAddrIn), .icDoneOut(icDoneOut), .icLineOut(icLineOut),
    .dcReqIn(dcReqIn), .dcWriteIn(dcWriteIn), .dcAddrIn(dcAddrIn), .dcLineIn(dcLineIn),
    .dcDoneOut(dcDoneOut), .dcLineOut(dcLineOut),
    .ioReqIn(ioReqIn), .ioWriteIn(ioWriteIn), .ioSizeIn(ioSizeIn), .ioAddrIn(ioAddrIn),
    .ioDataIn(ioDataIn), .ioDoneOut(ioDoneOut), .ioDataOut(ioDataOut), .busyOut(busyOut)
  );

  always #5 clkIn = ~clkIn;

  // RAM bus model: data for last cycle's address appears this cycle; writes commit each cycle.
  always @(negedge clkIn) begin
    memIn = ram[prev_addr[RAM_W-1:0]];
    if (readWriteOut === 1'b0) ram[memAddr[RAM_W-1:0]] = memOut;
    prev_addr = memAddr;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'b11) ? 4 : int'(s);
  endfunction

  function automatic logic [127:0] gold_bytes(input logic [31:0] start, input int n);
    logic [127:0] v = '0;
    logic [31:0]  a;
    for (int i = 0; i < n; i++) begin
      a = start + i;
      v[8*i +: 8] = gold[a[RAM_W-1:0]];
    end
    return v;
  endfunction

  function automatic logic [127:0] ram_bytes(input logic [31:0] start, input int n);
    logic [127:0] v = '0;
    logic [31:0]  a;
    for (int i = 0; i < n; i++) begin
      a = start + i;
      v[8*i +: 8] = ram[a[RAM_W-1:0]];
    end
    return v;
  endfunction

  task automatic gold_write(input logic [31:0] start, input int n, input logic [127:0] d);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + i;
      gold[a[RAM_W-1:0]] = d[8*i +: 8];
    end
  endtask

  function automatic logic [127:0] mask_bytes(input logic [127:0] d, input int n);
    logic [127:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction

  // One complete transaction for a single requester, checked cycle by cycle.
  task automatic run_txn(input string tag, input int kind, input bit wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [127:0] wdata, input int clear_at);
    int n, k;
    bit done;
    logic [31:0]  start;
    logic [127:0] exp, obs;
    logic [2:0]   done_mask;
    n     = (kind == K_IO) ? size_bytes(size) : BS;
    start = (kind == K_IO) ? addr : (addr << BW);
    exp   = wr ? mask_bytes(wdata, n) : gold_bytes(start, n);
    if (wr) gold_write(start, n, wdata);
    done_mask = (kind == K_IC) ? 3'b100 : (kind == K_DC) ? 3'b010 : 3'b001;
    case (kind)
      K_IO: begin
        ioReqIn = 1; ioWriteIn = wr; ioSizeIn = size; ioAddrIn = addr; ioDataIn = wdata[31:0];
      end
      K_DC: begin
        dcReqIn = 1; dcWriteIn = wr; dcAddrIn = addr[27:0]; dcLineIn = wdata;
      end
      default: begin
        icReqIn = 1; icAddrIn = addr[27:0];
      end
    endcase
    k = -1;
    done = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clkIn);
      clearIn = 0;
      if (busyOut) k++;
      if (busyOut && k < n) begin
        check({tag, " addr"}, memAddr, start + k);
        check({tag, " rw"}, readWriteOut, !wr);
        if (wr) check({tag, " wbyte"}, memOut, wdata[8*k +: 8]);
      end
      if (busyOut && k == clear_at) clearIn = 1;
      if (icDoneOut || dcDoneOut || ioDoneOut) begin
        done = 1;
        check({tag, " done owner"}, {icDoneOut, dcDoneOut, ioDoneOut}, done_mask);
        check({tag, " latency"}, k, wr ? n : n + 1);
        check({tag, " done rw"}, readWriteOut, 1'b1);
        if (!wr) begin
          obs = (kind == K_IO) ? {96'b0, ioDataOut} : (kind == K_DC) ? dcLineOut : icLineOut;
          check({tag, " rdata"}, obs, exp);
        end
        ioReqIn = 0; dcReqIn = 0; icReqIn = 0;
      end
    end
    check({tag, " completed"}, done, 1'b1);
    ioReqIn = 0; dcReqIn = 0; icReqIn = 0;
    @(negedge clkIn);
    check({tag, " idle after"}, {busyOut, icDoneOut, dcDoneOut, ioDoneOut}, 4'b0000);
    if (wr) check({tag, " ram"}, ram_bytes(start, n), exp);
  endtask

  initial begin
    int k, n_done, order_code, ic_pulses;
    logic [127:0] line, exp_io, exp_ic, dc_wr;
    logic [2:0]   dn;

    resetIn = 0; clearIn = 0;
    icReqIn = 0; icAddrIn = '0;
    dcReqIn = 0; dcWriteIn = 0; dcAddrIn = '0; dcLineIn = '0;
    ioReqIn = 0; ioWriteIn = 0; ioSizeIn = 2'b00; ioAddrIn = '0; ioDataIn = '0;
    for (int i = 0; i < (1 << RAM_W); i++) begin
      ram[i]  = 8'($urandom);
      gold[i] = ram[i];
    end

    // Reset state
    repeat (2) @(negedge clkIn);
    check("reset addr", memAddr, 32'h0);
    check("reset memOut", memOut, 8'h0);
    check("reset rw", readWriteOut, 1'b1);
    check("reset flags", {busyOut, icDoneOut, dcDoneOut, ioDoneOut}, 4'b0000);
    check("reset lines", {icLineOut, dcLineOut, ioDataOut}, '0);
    resetIn = 1;
    @(negedge clkIn);

    // ICache refill of a known ramp
    for (int i = 0; i < BS; i++) begin
      ram[32'h1000 + i]  = 8'(i);
      gold[32'h1000 + i] = 8'(i);
    end
    run_txn("ic refill", K_IC, 0, 32'h100, 2'b00, '0, -1);
    check("ic line value", icLineOut, 128'h0F0E0D0C0B0A09080706050403020100);

    // DCache writeback A0..AF
    for (int i = 0; i < BS; i++) line[8*i +: 8] = 8'(8'hA0 + i);
    run_txn("dc writeback", K_DC, 1, 32'h200, 2'b00, line, -1);

    // MMIO word read and half write
    ram[32'h30000] = 8'h11; ram[32'h30001] = 8'h22; ram[32'h30002] = 8'h33; ram[32'h30003] = 8'h44;
    gold[32'h30000] = 8'h11; gold[32'h30001] = 8'h22; gold[32'h30002] = 8'h33; gold[32'h30003] = 8'h44;
    run_txn("io word read", K_IO, 0, 32'h30000, 2'b11, '0, -1);
    check("io word value", ioDataOut, 32'h44332211);
    run_txn("io half write", K_IO, 1, 32'h30004, 2'b10, 128'hBEEF, -1);
    check("io half bytes", {ram[32'h30005], ram[32'h30004]}, 16'hBEEF);

    // MMIO byte read zero-extends; unaligned half read carries across lines
    run_txn("io byte read", K_IO, 0, 32'h30002, 2'b01, '0, -1);
    run_txn("io half cross", K_IO, 0, 32'h0000FFFF, 2'b10, '0, -1);

    // Three requests rising together
    exp_io = gold_bytes(32'h30020, 4);
    exp_ic = gold_bytes(32'h3400, BS);
    dc_wr  = {$urandom, $urandom, $urandom, $urandom};
    gold_write(32'h3300, BS, dc_wr);
    ioReqIn = 1; ioWriteIn = 0; ioSizeIn = 2'b11; ioAddrIn = 32'h30020;
    dcReqIn = 1; dcWriteIn = 1; dcAddrIn = 28'h330; dcLineIn = dc_wr;
    icReqIn = 1; icAddrIn = 28'h340;
    n_done = 0;
    order_code = 0;
    for (int c = 0; c < 200 && n_done < 3; c++) begin
      @(negedge clkIn);
      dn = {icDoneOut, dcDoneOut, ioDoneOut};
      if (dn != 3'b000) begin
        check("simul single done", $countones(dn), 1);
        if (ioDoneOut) begin
          order_code = order_code * 4 + K_IO;
          check("simul io data", ioDataOut, exp_io[31:0]);
          ioReqIn = 0;
        end
        if (dcDoneOut) begin
          order_code = order_code * 4 + K_DC;
          dcReqIn = 0;
        end
        if (icDoneOut) begin
          order_code = order_code * 4 + K_IC;
          check("simul ic data", icLineOut, exp_ic);
          icReqIn = 0;
        end
        n_done++;
      end
    end
    check("simul done count", n_done, 3);
    check("simul grant order", order_code, K_IO * 16 + K_DC * 4 + K_IC);
    check("simul dc ram", ram_bytes(32'h3300, BS), dc_wr);
    ioReqIn = 0; dcReqIn = 0; icReqIn = 0;
    @(negedge clkIn);

    // Flush at byte 5 of an ICache refill
    icReqIn = 1; icAddrIn = 28'h350;
    k = -1;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(negedge clkIn);
      if (busyOut) k++;
    end
    check("ic clear reached byte5", k, 5);
    clearIn = 1;
    @(negedge clkIn);
    clearIn = 0;
    icReqIn = 0;
    check("ic clear idle", {busyOut, icDoneOut, readWriteOut}, 3'b001);
    ic_pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clkIn);
      if (icDoneOut) ic_pulses++;
    end
    check("ic clear no done", ic_pulses, 0);

    // The same flush during a DCache writeback changes nothing
    run_txn("dc wb clear", K_DC, 1, 32'h360, 2'b00, {$urandom, $urandom, $urandom, $urandom}, 5);

    // Asynchronous reset in the middle of a DCache refill
    dcReqIn = 1; dcWriteIn = 0; dcAddrIn = 28'h370;
    k = -1;
    for (int c = 0; c < 40 && k < 7; c++) begin
      @(negedge clkIn);
      if (busyOut) k++;
    end
    check("rst reached byte7", k, 7);
    #2 resetIn = 0;
    #1;
    check("rst async addr", memAddr, 32'h0);
    check("rst async memOut", memOut, 8'h0);
    check("rst async rw", readWriteOut, 1'b1);
    check("rst async flags", {busyOut, icDoneOut, dcDoneOut, ioDoneOut}, 4'b0000);
    check("rst async lines", {icLineOut, dcLineOut, ioDataOut}, '0);
    dcReqIn = 0;
    @(negedge clkIn);
    resetIn = 1;
    @(negedge clkIn);
    run_txn("post-reset io", K_IO, 0, 32'h30000, 2'b11, '0, -1);

    // Randomized single-requester traffic against the golden memory
    for (int t = 0; t < 40; t++) begin
      int          kind;
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] a;
      kind = int'($urandom_range(K_IO, K_IC));
      wr   = (kind == K_IC) ? 1'b0 : 1'($urandom);
      sz   = 2'($urandom_range(1, 3));
      a    = (kind == K_IO) ? $urandom_range(0, 32'h3FFF0) : $urandom_range(0, 32'h3FFF);
      run_txn("random", kind, wr, a, sz, {$urandom, $urandom, $urandom, $urandom},
              (kind == K_DC) ? int'($urandom_range(0, 20)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single owner of the byte-wide RAM port.
- Arbitrates and sequences three requesters:
  - MMIO single accesses of 1, 2 or 4 bytes from the load/store path.
  - DCache line refills and line writebacks.
  - ICache line refills.
- Each granted transaction is serialized into back-to-back byte cycles. Completion is signalled with a one-cycle done pulse carrying the assembled data.
- Sits between the two cache cores and the RAM/IO bus, replacing ad-hoc per-cache loading logic.

Parameters:
- BLOCK_WIDTH, 4, log2 of line size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes; the line bus is BLOCK_SIZE*8 bits.

Ports:
- clkIn in 1: system clock; all state updates on the rising edge.
- resetIn in 1: reset, asynchronous, active-low.
- clearIn in 1: branch-mispredict flush.
- memIn in 8: byte read from the RAM port.
- memAddr out 32: RAM byte address (registered).
- memOut out 8: RAM write byte (registered).
- readWriteOut out 1: 1 = read, 0 = write (registered).
- icReqIn in 1: ICache line-refill request; level, held until icDoneOut.
- icAddrIn in 32-BLOCK_WIDTH: ICache line address [31:BLOCK_WIDTH].
- icDoneOut out 1: ICache refill-complete pulse.
- icLineOut out BLOCK_SIZE*8: ICache refill data; byte i at bits [8i+7:8i].
- dcReqIn in 1: DCache request; level, held until dcDoneOut.
- dcWriteIn in 1: DCache direction; 1 = writeback, 0 = refill.
- dcAddrIn in 32-BLOCK_WIDTH: DCache line address.
- dcLineIn in BLOCK_SIZE*8: DCache writeback data.
- dcDoneOut out 1: DCache done pulse.
- dcLineOut out BLOCK_SIZE*8: DCache refill data.
- ioReqIn in 1: MMIO request; level, held until ioDoneOut.
- ioWriteIn in 1: MMIO direction; 1 = write.
- ioSizeIn in 2: MMIO size; 01 = byte, 10 = half, 11 = word, 00 = illegal (ignored).
- ioAddrIn in 32: MMIO byte address.
- ioDataIn in 32: MMIO write data, little-endian.
- ioDoneOut out 1: MMIO done pulse.
- ioDataOut out 32: MMIO read data, zero-extended above size.
- busyOut out 1: high whenever state != IDLE.

Behaviour:
- Reset (resetIn low, asynchronous):
  - State goes to IDLE and the byte counter clears.
  - memAddr=0, memOut=0, readWriteOut=1.
  - All done pulses 0, busyOut=0.
  - icLineOut, dcLineOut and ioDataOut clear to 0.
  - Reset mid-transaction abandons it silently; requesters must re-request.
- States: IDLE, XFER, DONE.
- IDLE:
  - At each edge, pick the highest-priority asserted request: IO > DC > IC (IO requires ioSizeIn != 00).
  - Latch the requester ID, direction, start address and byte count N. N = BLOCK_SIZE for lines; 1, 2 or 4 for IO.
  - Latch the write data and go to XFER.
  - Arbitration is non-preemptive. A request arriving mid-transaction waits until the next IDLE.
- XFER, byte address and write data:
  - In cycle c0+i (c0 = first cycle after grant, i = 0..N-1), memAddr = start + i.
  - Line start address is {addr, BLOCK_WIDTH'b0}. IO start address is ioAddrIn with no alignment enforced, and the address carries into upper bits.
  - Writes: readWriteOut=0 and memOut = byte i of the latched data; the RAM commits at the end of that cycle.
  - Reads: readWriteOut=1. memIn for the address presented in cycle c is valid and captured at the end of cycle c+1, into byte lane i of the destination register.
- Transaction completion:
  - Write: after byte N-1 is presented, go to DONE. The DONE cycle is c0+N.
  - Read: go to DONE after capturing byte N-1 at the end of cycle c0+N. The DONE cycle is c0+N+1.
- DONE:
  - Assert exactly one done pulse for the owner, with readWriteOut=1.
  - Output data is stable from the DONE cycle until the next grant to the same requester.
  - Next state is IDLE. A held request is re-granted no earlier than the cycle after IDLE, so the requester must drop its request in the DONE cycle.
- clearIn:
  - While owner = IC and state is XFER or DONE, abort to IDLE at the next edge. No icDoneOut is issued and readWriteOut=1.
  - clearIn has no effect on DC or IO transactions (writebacks and MMIO have side effects).
  - clearIn in IDLE suppresses an IC grant in that cycle only.
- Simultaneous IO and DC requests: IO wins and DC waits; no starvation guarantee beyond this fixed priority.
- Write latency is N+1 cycles from the grant edge to the done pulse; read latency is N+2.

Test Plan:
- ICache refill, BLOCK_SIZE=16, icAddrIn=0x0000100, RAM[0x1000+i]=i:
  - memAddr steps 0x1000..0x100F on consecutive cycles.
  - icDoneOut pulses once, 18 cycles after grant.
  - icLineOut = 0x0F0E..0100.
- DCache writeback of dcAddrIn=0x0000200, dcLineIn bytes 0xA0..0xAF:
  - readWriteOut=0 for 16 cycles; RAM[0x2000..0x200F] = 0xA0..0xAF.
  - dcDoneOut pulses with readWriteOut=1 in that cycle.
- IO word read at 0x30000, RAM bytes 11,22,33,44 → ioDataOut=0x44332211. IO half write 0xBEEF at 0x30004 → bytes EF,BE written, ioDoneOut after 3 cycles.
- ioReqIn, dcReqIn and icReqIn rise in the same cycle → grant order is IO, DC, IC. Each done pulse appears once and no transactions overlap.
- clearIn asserted at byte 5 of an IC refill → IDLE next cycle, no icDoneOut, busyOut=0. The same clearIn during a DC writeback leaves all 16 bytes written.
- resetIn driven low asynchronously mid-DC-refill → all outputs take their reset values immediately, without waiting for a clock edge. After release, a new ioReqIn is granted normally.
